// File: rtl/pcm_i2s_tx_pkg.sv
// Shared constants for the PCM-to-I2S output stage.
// Link mode encodings, default geometry and the sticky status record.
package pcm_i2s_tx_pkg;

    localparam int unsigned I2S_LJ      = 0;
    localparam int unsigned I2S_PHILIPS = 1;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_SLOT_BITS  = 16;
    localparam int unsigned DEF_BCLK_DIV   = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } status_t;

endpackage

// File: rtl/pcm_i2s_tx_if.sv
// PCM sample stream into the I2S transmitter: one-cycle valid strobe plus data.
interface pcm_i2s_tx_if
    import pcm_i2s_tx_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] pcm_data;
    logic              pcm_valid;

    modport master (
        output pcm_data,
        output pcm_valid
    );

    modport slave (
        input pcm_data,
        input pcm_valid
    );

endinterface

// File: rtl/pcm_sync_fifo.sv
// Single-clock sample FIFO with synchronous flush; full push+pop is allowed,
// empty pop is ignored (no bypass of a same-cycle push).
module pcm_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_q];

    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/pcm_i2s_tx.sv
// Mono PCM to I2S / left-justified serialiser; the same sample fills both slots.
// BCLK and LRCLK are derived from clk by division; every output is a flop.
module pcm_i2s_tx
    import pcm_i2s_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SLOT_BITS  = DEF_SLOT_BITS,
    parameter int unsigned BCLK_DIV   = DEF_BCLK_DIV,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned I2S_DELAY  = I2S_PHILIPS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    pcm_i2s_tx_if.slave                   pcm,
    input  logic                          clr_status,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned DIV_W = $clog2(BCLK_DIV);
    localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);
    localparam int unsigned SR_W  = 2 * SLOT_BITS;

    localparam logic [DIV_W-1:0] DivMax  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DivHalf = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BitMax  = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] BitSlot = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] BitLoad = BIT_W'(I2S_DELAY);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d, bit_nxt;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              en_q;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sdata_q, sdata_d;
    status_t           status_q, status_d;

    logic              fall, load, push;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [SLOT_BITS-1:0] slot_w;

    pcm_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (!enable),
        .push    (push),
        .pop     (load),
        .wdata   (pcm.pcm_data),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        fall    = enable && (div_q == DivMax);
        bit_nxt = (bit_q == BitMax) ? '0 : bit_q + BIT_W'(1);
        // Left-justified also loads on the very first enabled cycle so slot 0 is not lost.
        load    = enable && ((fall && (bit_nxt == BitLoad)) ||
                             ((I2S_DELAY == I2S_LJ) && !en_q));
        push    = pcm.pcm_valid && enable;

        slot_w = '0;
        slot_w[SLOT_BITS-1 -: DATA_W] = fifo_rdata;

        div_d = '0;
        bit_d = '0;
        sr_d  = '0;
        if (enable) begin
            div_d = fall ? '0 : div_q + DIV_W'(1);
            bit_d = fall ? bit_nxt : bit_q;
            if (load) begin
                sr_d = fifo_empty ? '0 : {slot_w, slot_w};
            end else if (fall) begin
                sr_d = {sr_q[SR_W-2:0], 1'b0};
            end else begin
                sr_d = sr_q;
            end
        end

        bclk_d  = (div_d >= DivHalf);
        lrclk_d = (bit_d >= BitSlot);
        sdata_d = sr_d[SR_W-1];

        status_d.overflow  = (push && fifo_full && !load) ||
                             (status_q.overflow && !clr_status);
        status_d.underflow = (load && fifo_empty) ||
                             (status_q.underflow && !clr_status);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            en_q     <= 1'b0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            status_q <= '0;
        end else begin
            div_q    <= div_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            en_q     <= enable;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            status_q <= status_d;
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign overflow  = status_q.overflow;
    assign underflow = status_q.underflow;

endmodule
